// File: rtl/edge_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module   : edge_frame_writer
//  Brief    : Captures one frame of 4-bit pixels per start pulse, packs four
//             pixels per 16-bit word and writes the words to a 16-bit SRAM
//             port through a 2-entry {addr,data} buffer; lost words raise a
//             sticky overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module edge_frame_writer #(
   parameter int          IMG_W     = 640,
   parameter int          IMG_H     = 480,
   parameter int          ADDR_W    = 18,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        pix_in,
   input  logic              pix_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic              busy,
   output logic              frame_done,
   output logic              overflow
);

   localparam int                  c_TOTAL    = IMG_W * IMG_H;
   localparam int                  c_CNT_W    = $clog2(c_TOTAL + 1);
   localparam logic [c_CNT_W-1:0]  c_LAST_PIX = c_CNT_W'(c_TOTAL - 1);
   localparam logic [ADDR_W-1:0]   c_BASE     = ADDR_W'(BASE_ADDR);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_FLUSH   = 2'd2
   } state_t;

   state_t              r_state;
   logic [c_CNT_W-1:0]  r_pix_cnt;
   logic [1:0]          r_nib;
   logic [11:0]         r_pix_buf;
   logic [ADDR_W-1:0]   r_word_addr;
   logic                r_overflow;

   logic [ADDR_W-1:0]   r_fifo_addr [2];
   logic [15:0]         r_fifo_data [2];
   logic                r_rd_ptr;
   logic                r_wr_ptr;
   logic [1:0]          r_count;

   logic                w_consume;
   logic                w_push;
   logic                w_pop;
   logic                w_full;
   logic                w_push_ok;
   logic                w_drop;
   logic [15:0]         w_word;

   // A word is complete on the fourth consumed pixel; it is only lost when
   // the buffer is full and the head is not leaving in the same cycle.
   assign w_consume = (r_state == S_CAPTURE) && pix_valid;
   assign w_push    = w_consume && (r_nib == 2'd3);
   assign w_pop     = (r_count != 2'd0) && mem_ready;
   assign w_full    = (r_count == 2'd2);
   assign w_push_ok = w_push && (!w_full || w_pop);
   assign w_drop    = w_push && w_full && !w_pop;
   assign w_word    = {pix_in, r_pix_buf};

   // Memory side is driven straight from the buffer head, so it is stable
   // for as long as the head entry is not popped.
   assign mem_we     = (r_count != 2'd0);
   assign mem_addr   = r_fifo_addr[r_rd_ptr];
   assign mem_wdata  = r_fifo_data[r_rd_ptr];
   assign busy       = (r_state != S_IDLE);
   assign overflow   = r_overflow;
   assign frame_done = (r_state == S_FLUSH) && (r_count == 2'd1) && mem_ready;

   // Frame sequencing, pixel packing and word-address generation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_pix_cnt   <= '0;
         r_nib       <= 2'd0;
         r_pix_buf   <= 12'd0;
         r_word_addr <= c_BASE;
         r_overflow  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state     <= S_CAPTURE;
                  r_pix_cnt   <= '0;
                  r_nib       <= 2'd0;
                  r_word_addr <= c_BASE;
                  r_overflow  <= 1'b0;
               end
            end
            S_CAPTURE: begin
               if (w_drop) begin
                  r_overflow <= 1'b1;
               end
               if (pix_valid) begin
                  r_nib     <= r_nib + 2'd1;
                  r_pix_cnt <= r_pix_cnt + c_CNT_W'(1);
                  case (r_nib)
                     2'd0:    r_pix_buf[3:0]  <= pix_in;
                     2'd1:    r_pix_buf[7:4]  <= pix_in;
                     2'd2:    r_pix_buf[11:8] <= pix_in;
                     default: r_word_addr     <= r_word_addr + ADDR_W'(1);
                  endcase
                  if (r_pix_cnt == c_LAST_PIX) begin
                     r_state <= S_FLUSH;
                  end
               end
            end
            S_FLUSH: begin
               if ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop)) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Two-entry word buffer; simultaneous push and pop keep occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fifo_addr[0] <= '0;
         r_fifo_addr[1] <= '0;
         r_fifo_data[0] <= 16'd0;
         r_fifo_data[1] <= 16'd0;
         r_rd_ptr       <= 1'b0;
         r_wr_ptr       <= 1'b0;
         r_count        <= 2'd0;
      end else begin
         if (w_push_ok) begin
            r_fifo_addr[r_wr_ptr] <= r_word_addr;
            r_fifo_data[r_wr_ptr] <= w_word;
            r_wr_ptr              <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_edge_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_edge_frame_writer
//  Brief    : Scoreboard bench for edge_frame_writer (4x2 and 4x3 frames).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_edge_frame_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        start3 = 1'b0;
   logic [3:0]  pix_in = 4'd0;
   logic        pix_valid = 1'b0;
   logic        mem_ready = 1'b0;

   logic [17:0] mem_addr, mem_addr3;
   logic [15:0] mem_wdata, mem_wdata3;
   logic        mem_we, mem_we3;
   logic        busy, busy3;
   logic        frame_done, frame_done3;
   logic        overflow, overflow3;

   int checks = 0;
   int failures = 0;
   int wr2 = 0, done2 = 0, wr3 = 0, done3 = 0;
   logic [33:0] q2[$];
   logic [33:0] q3[$];
   logic [33:0] e2, e3;
   logic        prev_stall = 1'b0;
   logic [17:0] prev_addr = '0;
   logic [15:0] prev_data = '0;

   edge_frame_writer #(.IMG_W(4), .IMG_H(2), .ADDR_W(18), .BASE_ADDR(32'h10)) dut (
      .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ready(mem_ready),
      .busy(busy), .frame_done(frame_done), .overflow(overflow)
   );

   edge_frame_writer #(.IMG_W(4), .IMG_H(3), .ADDR_W(18), .BASE_ADDR(32'h10)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .pix_in(pix_in), .pix_valid(pix_valid),
      .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_we(mem_we3), .mem_ready(mem_ready),
      .busy(busy3), .frame_done(frame_done3), .overflow(overflow3)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Monitor for the 4x2 instance: scoreboard pops on accepts, hold stability.
   always @(negedge clk) begin
      if (!rst && prev_stall && mem_we) begin
         check("hold_addr", mem_addr, prev_addr);
         check("hold_data", mem_wdata, prev_data);
      end
      prev_stall = mem_we && !mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_wdata;
      if (mem_we && mem_ready) begin
         wr2++;
         check("wr_expected", q2.size() != 0, 1);
         if (q2.size() != 0) begin
            e2 = q2.pop_front();
            check("wr_addr", mem_addr, e2[33:16]);
            check("wr_data", mem_wdata, e2[15:0]);
         end
      end
      if (frame_done) begin
         done2++;
         check("done_on_last_accept", mem_we && mem_ready && (q2.size() == 0), 1);
      end
   end

   // Monitor for the 4x3 instance.
   always @(negedge clk) begin
      if (mem_we3 && mem_ready) begin
         wr3++;
         check("wr3_expected", q3.size() != 0, 1);
         if (q3.size() != 0) begin
            e3 = q3.pop_front();
            check("wr3_addr", mem_addr3, e3[33:16]);
            check("wr3_data", mem_wdata3, e3[15:0]);
         end
      end
      if (frame_done3) begin
         done3++;
         check("done3_on_last_accept", mem_we3 && mem_ready && (q3.size() == 0), 1);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pix(input logic [3:0] v, input logic vld);
      pix_in    = v;
      pix_valid = vld;
      step();
   endtask

   task automatic stream(input int first, input int n, input bit gapped);
      for (int i = 0; i < n; i++) begin
         pix(4'(first + i), 1'b1);
         if (gapped) pix(4'hF, 1'b0);
      end
      pix_valid = 1'b0;
   endtask

   task automatic pulse_start(input bit sel3);
      if (sel3) start3 = 1'b1; else start = 1'b1;
      step();
      start  = 1'b0;
      start3 = 1'b0;
   endtask

   task automatic wait_idle(input bit sel3, input int maxc, input string tag);
      int n = 0;
      while ((sel3 ? busy3 : busy) && n < maxc) begin
         step();
         n++;
      end
      check(tag, sel3 ? busy3 : busy, 0);
   endtask

   task automatic end_check(input string tag, input int w0, input int d0, input int expw);
      wait_idle(1'b0, 40, {tag, "_idle"});
      check({tag, "_writes"}, wr2 - w0, expw);
      check({tag, "_done"}, done2 - d0, 1);
      check({tag, "_q_empty"}, q2.size(), 0);
   endtask

   task automatic expect_two();
      q2.push_back({18'h10, 16'h4321});
      q2.push_back({18'h11, 16'h8765});
   endtask

   initial begin
      int w0, d0;
      step();
      step();
      check("rst_we", mem_we, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_data", mem_wdata, 0);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      check("rst_ovf", overflow, 0);
      rst = 1'b0;
      step();

      // Basic frame, memory always ready
      mem_ready = 1'b1;
      w0 = wr2; d0 = done2;
      expect_two();
      pulse_start(1'b0);
      check("basic_busy", busy, 1);
      stream(1, 8, 1'b0);
      end_check("basic", w0, d0, 2);

      // Gapped pixel valid, garbage on idle cycles
      w0 = wr2; d0 = done2;
      expect_two();
      pulse_start(1'b0);
      stream(1, 8, 1'b1);
      end_check("gapped", w0, d0, 2);

      // Backpressure: both words held in the buffer
      mem_ready = 1'b0;
      w0 = wr2; d0 = done2;
      expect_two();
      pulse_start(1'b0);
      stream(1, 8, 1'b0);
      for (int i = 0; i < 12; i++) step();
      check("bp_we", mem_we, 1);
      check("bp_addr", mem_addr, 18'h10);
      check("bp_data", mem_wdata, 16'h4321);
      check("bp_ovf", overflow, 0);
      check("bp_busy", busy, 1);
      check("bp_no_writes", wr2 - w0, 0);
      mem_ready = 1'b1;
      end_check("bp", w0, d0, 2);

      // Overflow on the 4x3 instance: third word dropped
      mem_ready = 1'b0;
      w0 = wr3; d0 = done3;
      q3.push_back({18'h10, 16'h4321});
      q3.push_back({18'h11, 16'h8765});
      pulse_start(1'b1);
      stream(1, 12, 1'b0);
      check("ov_flag", overflow3, 1);
      check("ov_addr", mem_addr3, 18'h10);
      check("ov_data", mem_wdata3, 16'h4321);
      check("ov_busy", busy3, 1);
      mem_ready = 1'b1;
      wait_idle(1'b1, 40, "ov_idle");
      check("ov_writes", wr3 - w0, 2);
      check("ov_done", done3 - d0, 1);
      check("ov_sticky", overflow3, 1);
      w0 = wr3; d0 = done3;
      pulse_start(1'b1);
      check("ov_cleared", overflow3, 0);
      q3.push_back({18'h10, 16'h4321});
      q3.push_back({18'h11, 16'h8765});
      q3.push_back({18'h12, 16'hCBA9});
      stream(1, 12, 1'b0);
      wait_idle(1'b1, 40, "ov2_idle");
      check("ov2_writes", wr3 - w0, 3);
      check("ov2_done", done3 - d0, 1);
      check("ov2_flag", overflow3, 0);

      // Ignored inputs: pixels in IDLE, start during CAPTURE
      w0 = wr2; d0 = done2;
      stream(9, 6, 1'b0);
      check("ign_idle_writes", wr2 - w0, 0);
      check("ign_idle_busy", busy, 0);
      expect_two();
      pulse_start(1'b0);
      stream(1, 4, 1'b0);
      start = 1'b1;
      pix(4'd5, 1'b1);
      start = 1'b0;
      stream(6, 3, 1'b0);
      end_check("ign", w0, d0, 2);

      // Asynchronous reset after five pixels
      mem_ready = 1'b0;
      w0 = wr2; d0 = done2;
      pulse_start(1'b0);
      stream(1, 5, 1'b0);
      check("ar_we_before", mem_we, 1);
      #2 rst = 1'b1;
      #1;
      check("ar_we", mem_we, 0);
      check("ar_addr", mem_addr, 0);
      check("ar_data", mem_wdata, 0);
      check("ar_busy", busy, 0);
      check("ar_done", frame_done, 0);
      check("ar_ovf", overflow, 0);
      mem_ready = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("ar_no_writes", wr2 - w0, 0);
      check("ar_no_done", done2 - d0, 0);
      w0 = wr2; d0 = done2;
      expect_two();
      pulse_start(1'b0);
      stream(1, 8, 1'b0);
      end_check("ar_clean", w0, d0, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
